// File: rtl/uart_pkg.sv
// Shared types, divider helper and debug command bytes for the debug UART.
package uart_pkg;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitIdle
  } rx_state_t;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_t;

  // Oversample divider, clamped so a too-fast baud still ticks every cycle.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned os);
    int unsigned d;
    d = clk_hz / (baud * os);
    return (d == 0) ? 1 : d;
  endfunction

  localparam logic [7:0] CmdPing  = 8'h50;
  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] CmdHalt  = 8'h48;
  localparam logic [7:0] CmdGo    = 8'h47;
  localparam logic [7:0] CmdAck   = 8'h41;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle oversample tick every DIV clocks.
module uart_baud_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  output logic os_tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;

  assign os_tick = (cnt_q == CntW'(DIV - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (os_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/debug_uart.sv
// 8N1 UART front end for the debug controller: oversampled RX, cycle-exact TX.
module debug_uart
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rx_serial,
  output logic       tx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int unsigned Div       = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned BitCycles = Div * OVERSAMPLE;
  localparam int unsigned HalfOs    = OVERSAMPLE / 2;
  localparam int unsigned OsCntW    = $clog2(OVERSAMPLE);
  localparam int unsigned TxCntW    = $clog2(BitCycles);

  logic os_tick;

  uart_baud_tick #(
    .DIV(Div)
  ) u_baud_tick (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .os_tick(os_tick)
  );

  // ---------------- RX ----------------
  logic [1:0]        sync_q;
  logic              rx_sync;
  rx_state_t         rx_state_q, rx_state_d;
  logic [OsCntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_idx_q, rx_idx_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;

  assign rx_sync = sync_q[1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q     <= 2'b11;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx_serial};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (!rx_sync) begin
          rx_cnt_d   = '0;
          rx_state_d = RxStart;
        end
      end
      RxStart: begin
        if (os_tick) begin
          if (rx_cnt_q == OsCntW'(HalfOs - 1)) begin
            rx_cnt_d = '0;
            rx_idx_d = '0;
            // A start bit that is high again at mid-bit was only a glitch.
            rx_state_d = rx_sync ? RxIdle : RxData;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxData: begin
        if (os_tick) begin
          if (rx_cnt_q == OsCntW'(OVERSAMPLE - 1)) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_d = RxStop;
            else                  rx_idx_d   = rx_idx_q + 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxStop: begin
        if (os_tick) begin
          if (rx_cnt_q == OsCntW'(OVERSAMPLE - 1)) begin
            rx_cnt_d = '0;
            if (rx_sync) begin
              rx_byte_d  = rx_shift_q;
              rx_valid_d = 1'b1;
              rx_state_d = RxIdle;
            end else begin
              rx_err_d   = 1'b1;
              rx_state_d = RxWaitIdle;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      RxWaitIdle: begin
        if (rx_sync) rx_state_d = RxIdle;
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  assign rx_byte      = rx_byte_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_err_q;

  // ---------------- TX ----------------
  tx_state_t         tx_state_q, tx_state_d;
  logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_idx_q, tx_idx_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_q, tx_line_d;
  logic              tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == TxCntW'(BitCycles - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_line_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TxIdle: begin
        tx_cnt_d = '0;
        if (tx_start) begin
          tx_shift_d = tx_byte;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_bit_end) begin
          tx_idx_d   = '0;
          tx_state_d = TxData;
        end
      end
      TxData: begin
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_idx_q == 3'd7) tx_state_d = TxStop;
          else                  tx_idx_d   = tx_idx_q + 1'b1;
        end
      end
      TxStop: begin
        if (tx_bit_end) tx_state_d = TxIdle;
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  // Line level is registered from the next state so the pin never glitches.
  always_comb begin
    tx_line_d = 1'b1;
    unique case (tx_state_d)
      TxStart: tx_line_d = 1'b0;
      TxData:  tx_line_d = tx_shift_d[0];
      default: tx_line_d = 1'b1;
    endcase
  end

  assign tx_serial = tx_q;
  assign tx_busy   = (tx_state_q != TxIdle);

endmodule

// File: tb/tb_debug_uart.sv
// Directed bench for debug_uart at 32 MHz / 1 Mbaud / 16x (32 clocks per bit).
module tb_debug_uart;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_drv = 1'b1;
  logic       loop = 1'b0;
  logic       rx_line;
  logic       tx_serial;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy;

  assign rx_line = loop ? tx_serial : rx_drv;

  debug_uart #(
    .CLK_FREQ_HZ(32_000_000),
    .BAUD       (1_000_000),
    .OVERSAMPLE (16)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .rx_serial   (rx_line),
    .tx_serial   (tx_serial),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  int both = 0;
  int busy_cnt = 0;
  int vcyc = 0;
  logic [7:0] vbytes[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      vcnt <= vcnt + 1;
      vcyc <= cyc;
      vbytes.push_back(rx_byte);
    end
    if (rx_frame_err) ecnt <= ecnt + 1;
    if (rx_valid && rx_frame_err) both <= both + 1;
    if (tx_busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_drv = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (32) @(negedge clk);
    end
    rx_drv = stop;
    repeat (32) @(negedge clk);
  endtask

  task automatic wait_vcnt(input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (vcnt < n && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(vcnt >= n), 1);
  endtask

  // Leaves the caller on the first negedge after the accept edge (frame cycle 0).
  task automatic tx_send(input logic [7:0] b);
    int k;
    k = 0;
    while (tx_busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    tx_byte  = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Samples mid-bit for all ten bits; returns at frame cycle 304.
  task automatic tx_capture(output logic [9:0] bits);
    repeat (16) @(negedge clk);
    bits[0] = tx_serial;
    for (int i = 1; i < 10; i++) begin
      repeat (32) @(negedge clk);
      bits[i] = tx_serial;
    end
  endtask

  logic [9:0] f1, f2;
  logic       exp41[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
  int v0, e0, b0, t0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_serial", 32'(tx_serial), 1);
    check("rst_rx_byte", 32'(rx_byte), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_frame_err", 32'(rx_frame_err), 0);
    check("rst_tx_busy", 32'(tx_busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_pulse_after_release", 32'(vcnt + ecnt), 0);

    // RX good frame
    v0 = vcnt;
    e0 = ecnt;
    t0 = cyc;
    send_rx(8'h57, 1'b1);
    repeat (10) @(negedge clk);
    check("rx_good_count", 32'(vcnt - v0), 1);
    check("rx_good_byte", 32'(vbytes[v0]), 32'h57);
    check("rx_good_hold", 32'(rx_byte), 32'h57);
    check("rx_good_no_err", 32'(ecnt - e0), 0);
    check("rx_latency", 32'((vcyc - t0) >= 303 && (vcyc - t0) <= 309), 1);

    // Glitch
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_valid", 32'(vcnt - v0), 1);
    check("glitch_no_err", 32'(ecnt - e0), 0);

    // Framing error, then break
    send_rx(8'hA5, 1'b0);
    repeat (1000) @(negedge clk);
    check("ferr_count", 32'(ecnt - e0), 1);
    check("ferr_no_valid", 32'(vcnt - v0), 1);
    check("ferr_byte_kept", 32'(rx_byte), 32'h57);
    rx_drv = 1'b1;
    repeat (100) @(negedge clk);
    check("break_end_err", 32'(ecnt - e0), 1);
    check("break_end_valid", 32'(vcnt - v0), 1);

    // TX single byte
    b0 = busy_cnt;
    tx_send(8'h41);
    check("tx_busy_rise", 32'(tx_busy), 1);
    tx_capture(f1);
    for (int i = 0; i < 10; i++) check($sformatf("tx41_bit%0d", i), 32'(f1[i]), 32'(exp41[i]));
    repeat (15) @(negedge clk);
    check("tx_busy_319", 32'(tx_busy), 1);
    @(negedge clk);
    check("tx_busy_320", 32'(tx_busy), 0);
    check("tx_idle_line", 32'(tx_serial), 1);
    repeat (5) @(negedge clk);
    check("tx_busy_cycles", 32'(busy_cnt - b0), 320);

    // TX back-to-back with tx_start held
    b0 = busy_cnt;
    tx_byte  = 8'hDE;
    tx_start = 1'b1;
    @(negedge clk);
    check("b2b_accept1", 32'(tx_busy), 1);
    tx_byte = 8'hAD;
    tx_capture(f1);
    repeat (16) @(negedge clk);
    check("b2b_free_cycle", 32'(tx_busy), 0);
    @(negedge clk);
    check("b2b_accept2", 32'(tx_busy), 1);
    tx_start = 1'b0;
    tx_capture(f2);
    check("b2b_frame1", 32'(f1), 32'({1'b1, 8'hDE, 1'b0}));
    check("b2b_frame2", 32'(f2), 32'({1'b1, 8'hAD, 1'b0}));
    repeat (300) @(negedge clk);
    check("b2b_busy_cycles", 32'(busy_cnt - b0), 640);
    check("b2b_no_third", 32'(tx_busy), 0);

    // Loopback
    loop = 1'b1;
    v0 = vcnt;
    e0 = ecnt;
    tx_send(8'h00);
    tx_send(8'hFF);
    tx_send(8'h52);
    wait_vcnt(v0 + 3, 2000, "loop_timeout");
    repeat (400) @(negedge clk);
    check("loop_count", 32'(vcnt - v0), 3);
    check("loop_byte0", 32'(vbytes[v0]), 32'h00);
    check("loop_byte1", 32'(vbytes[v0+1]), 32'hFF);
    check("loop_byte2", 32'(vbytes[v0+2]), 32'h52);
    check("loop_no_err", 32'(ecnt - e0), 0);
    loop = 1'b0;

    // Async reset mid TX and mid RX frame
    tx_send(8'h48);
    repeat (100) @(negedge clk);
    rx_drv = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_tx_serial", 32'(tx_serial), 1);
    check("areset_tx_busy", 32'(tx_busy), 0);
    check("areset_rx_valid", 32'(rx_valid), 0);
    rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    e0 = ecnt;
    repeat (400) @(negedge clk);
    check("post_reset_no_valid", 32'(vcnt - v0), 0);
    check("post_reset_no_err", 32'(ecnt - e0), 0);
    check("post_reset_idle", 32'(tx_busy), 0);
    send_rx(8'h47, 1'b1);
    wait_vcnt(v0 + 1, 100, "post_reset_rx_timeout");
    check("post_reset_rx_byte", 32'(rx_byte), 32'h47);
    tx_send(8'h50);
    tx_capture(f1);
    check("post_reset_tx_frame", 32'(f1), 32'({1'b1, 8'h50, 1'b0}));
    repeat (40) @(negedge clk);
    check("valid_err_exclusive", 32'(both), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_uart.md
Name: debug_uart

Overview:
- 8N1 UART transceiver that sits directly upstream of the debug controller.
- Converts the external serial pins into a byte stream with a single-cycle valid, and serialises bytes handed back by the controller.
- RX uses 16x oversampling with mid-bit sampling and framing-error detection.
- TX uses an exact cycle-counted bit period with a start/busy handshake.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, RX samples per bit; must be even and at least 4.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- rx_serial  input  1  asynchronous serial input; idles high.
- tx_serial  output  1  serial output; idles high.
- rx_byte  output  8  last received byte; held stable until the next rx_valid.
- rx_valid  output  1  one-cycle pulse when a good frame has been received.
- rx_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- tx_byte  input  8  byte to send; sampled only on the accept cycle.
- tx_start  input  1  send request.
- tx_busy  output  1  high while a frame is in flight.

Behaviour:
- Reset values: tx_serial=1, rx_byte=0, rx_valid=0, rx_frame_err=0, tx_busy=0. Both FSMs go to IDLE and the RX synchroniser flops are set to 1.
- Reset mid-frame aborts the frame silently. No pulse is generated on reset release.

Derived constants:
- DIV = CLK_FREQ_HZ/(BAUD*OVERSAMPLE), integer division, minimum 1.
- BIT_CYCLES = DIV*OVERSAMPLE.

Baud tick:
- Free-running counter 0..DIV-1 produces a one-cycle os_tick when it reaches DIV-1.
- Used by RX only.

RX path:
- rx_serial passes through a 2-flop synchroniser; all RX logic uses the synchronised value.
- IDLE: on synchronised low, clear the sample counter and go to START.
- START: after OVERSAMPLE/2 ticks, sample the line.
  - High: false start, return to IDLE with no pulse.
  - Low: clear the counter, clear the bit index, go to DATA.
- DATA: every OVERSAMPLE ticks, sample one bit, LSB first, into the shift register. After bit 7, go to STOP.
- STOP: after OVERSAMPLE ticks, sample the line.
  - High: load rx_byte from the shift register, pulse rx_valid on that same edge, go to IDLE.
  - Low: pulse rx_frame_err, leave rx_byte unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until the synchronised line is high, then go to IDLE. This also covers a break condition.
- rx_valid and rx_frame_err are never high in the same cycle.
- A new start bit may be detected in the cycle right after returning to IDLE; no inter-frame gap is required.

TX path:
- Accept: tx_start && !tx_busy. On that edge, capture tx_byte and set tx_busy=1.
- tx_start while tx_busy is ignored.
- States: IDLE, START, DATA, STOP.
- tx_serial goes low on the cycle after accept. Each bit lasts exactly BIT_CYCLES clocks, timed by a private counter that is independent of os_tick.
- Bit order on the line: start (0), d0..d7, stop (1).
- tx_busy stays high for exactly 10*BIT_CYCLES cycles and falls on the edge that ends the stop bit.
- A tx_start on the first cycle with tx_busy=0 is accepted immediately, giving gapless back-to-back frames.
- The downstream controller may hold tx_start high continuously. Exactly one frame is sent per accept.
- TX and RX are fully independent and may be active at the same time. Loopback (tx_serial tied to rx_serial) must work.

Decomposition:
- Package uart_pkg holds:
  - typedef rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE};
  - typedef tx_state_t {IDLE, START, DATA, STOP};
  - localparam function computing DIV with the minimum-1 clamp;
  - debug command constants: 8'h50 'P', 8'h57 'W', 8'h52 'R', 8'h48 'H', 8'h47 'G', 8'h41 'A'.
- One sub-module, uart_baud_tick: the parameterised DIV counter producing os_tick.

Test Plan:
All scenarios use CLK_FREQ_HZ=32_000_000, BAUD=1_000_000, OVERSAMPLE=16, so DIV=2 and BIT_CYCLES=32.
- RX good frame: drive 8'h57 at 32 cycles/bit -> exactly one rx_valid with rx_byte=8'h57, about 305 cycles after the start edge. rx_frame_err stays 0.
- RX glitch and framing error:
  - A 5-cycle low pulse -> no rx_valid and no rx_frame_err.
  - Frame 8'hA5 with stop bit low -> one rx_frame_err pulse, rx_byte still holds the previous value.
  - Line held low for 1000 cycles -> no further pulses until the line goes high again.
- TX single byte: tx_byte=8'h41 with a one-cycle tx_start -> tx_serial reads 0,1,0,0,0,0,0,1,0,1 per 32-cycle bit. tx_busy is high for exactly 320 cycles.
- TX back-to-back with tx_start held high: bytes 8'hDE then 8'hAD, changed on the accept edge -> two contiguous frames, no idle gap, 640 busy cycles total.
- Loopback: tx_serial tied to rx_serial, send 8'h00, 8'hFF, 8'h52 -> three rx_valid pulses with matching rx_byte, in order.
- Async reset: assert RST_N low mid TX frame and mid RX frame -> tx_serial=1 and tx_busy=0 immediately. After release, no spurious rx_valid and the next frame works normally.
